// File: rtl/memshare_sched_pkg.sv
// rtl/memshare_sched_pkg.sv - shared types and defaults for the memshare scheduler
// Purpose: FSM state enum and the default share-group size used by
//          memshare_skid_sched and memshare_rr_pick.
// Ports:   none (package).
package memshare_sched_pkg;

  localparam int SHARE_GROUP_SIZE_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/memshare_rr_pick.sv
// rtl/memshare_rr_pick.sv - combinational round-robin pick
// Purpose: selects the first set request bit at index ptr, ptr+1, ... wrapping
//          modulo SHARE_GROUP_SIZE.
// Ports:   req  - request vector
//          ptr  - round-robin start index
//          gnt  - one-hot grant (zero when req is zero)
//          idx  - index of the granted bit (0 when req is zero)
module memshare_rr_pick
  import memshare_sched_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = SHARE_GROUP_SIZE_DEF,
  parameter int PTR_W            = $clog2(SHARE_GROUP_SIZE)
) (
  input  logic [SHARE_GROUP_SIZE-1:0] req,
  input  logic [PTR_W-1:0]            ptr,
  output logic [SHARE_GROUP_SIZE-1:0] gnt,
  output logic [PTR_W-1:0]            idx
);

  localparam int N = SHARE_GROUP_SIZE;

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/memshare_skid_sched.sv
// rtl/memshare_skid_sched.sv - shared-port grant scheduler with skid-buffer select
// Purpose: accepts a request-flag vector per column access and issues one grant
//          per cycle to the shared port in round-robin order. The first grant of
//          a vector accepted while idle is issued in the same cycle through the
//          pass-through path; remaining grants come from the registered path.
// Ports:   sys_clk, rstn (async, active-low)
//          rqst_flag_i / rqst_vld_i / rqst_rdy_o - request vector handshake
//          grant_o, grant_vld_o                  - one-hot grant and its valid
//          skid_sel_o                            - 0 pass-through, 1 registered
//          busy_o                                - high while serving pending bits
//          conflict_cnt_o                        - only with MEMSHARE_SCHED_STAT_EN:
//                                                  saturating count of accepted
//                                                  vectors with more than one bit
module memshare_skid_sched
  import memshare_sched_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = SHARE_GROUP_SIZE_DEF,
  parameter int PTR_W            = $clog2(SHARE_GROUP_SIZE)
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic [SHARE_GROUP_SIZE-1:0] rqst_flag_i,
  input  logic                        rqst_vld_i,
  output logic                        rqst_rdy_o,
  output logic [SHARE_GROUP_SIZE-1:0] grant_o,
  output logic                        grant_vld_o,
  output logic                        skid_sel_o,
`ifdef MEMSHARE_SCHED_STAT_EN
  output logic [15:0]                 conflict_cnt_o,
`endif
  output logic                        busy_o
);

  localparam int N = SHARE_GROUP_SIZE;

  sched_state_t   state, state_nxt;
  logic [N-1:0]   pending, pending_nxt;
  logic [N-1:0]   pick_req, pick_gnt;
  logic [PTR_W-1:0] ptr, pick_idx;
  logic           serving, rdy_int, accept;

  assign serving = (state == SERVE);
  // A new vector may enter while the last pending bit is being granted.
  assign rdy_int = !serving || $onehot(pending);
  assign accept  = rqst_vld_i && rdy_int;
  // Idle grants come straight from the incoming flags (zero latency).
  assign pick_req = serving ? pending : (accept ? rqst_flag_i : '0);

  memshare_rr_pick #(
    .SHARE_GROUP_SIZE(N),
    .PTR_W           (PTR_W)
  ) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  always_comb begin
    pending_nxt = pending & ~pick_gnt;
    state_nxt   = state;
    if (accept) begin
      // In SERVE the grant belongs to the old vector, so the new one loads whole.
      pending_nxt = serving ? rqst_flag_i : (rqst_flag_i & ~pick_gnt);
    end
    state_nxt = (pending_nxt != '0) ? SERVE : IDLE;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pending <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (|pick_gnt) begin
        ptr <= (pick_idx == PTR_W'(N - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

`ifdef MEMSHARE_SCHED_STAT_EN
  // A vector with more than one bit set means requesters collided on the port.
  logic multi_bit;
  assign multi_bit = (rqst_flag_i & (rqst_flag_i - 1'b1)) != '0;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt_o <= '0;
    end else if (accept && multi_bit && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`endif

  // Outputs are forced low combinationally so they drop the instant rstn falls.
  assign rqst_rdy_o  = rstn && rdy_int;
  assign grant_o     = rstn ? pick_gnt : '0;
  assign grant_vld_o = |grant_o;
  assign skid_sel_o  = rstn && serving;
  assign busy_o      = rstn && serving;

endmodule

// File: tb/tb_memshare_skid_sched.sv
// tb/tb_memshare_skid_sched.sv - self-checking bench for memshare_skid_sched
module tb_memshare_skid_sched;

  localparam int N = 5;

  logic         sys_clk;
  logic         rstn;
  logic [N-1:0] rqst_flag_i;
  logic         rqst_vld_i;
  logic         rqst_rdy_o;
  logic [N-1:0] grant_o;
  logic         grant_vld_o;
  logic         skid_sel_o;
  logic         busy_o;
`ifdef MEMSHARE_SCHED_STAT_EN
  logic [15:0]  conflict_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  memshare_skid_sched dut (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .rqst_flag_i(rqst_flag_i),
    .rqst_vld_i (rqst_vld_i),
    .rqst_rdy_o (rqst_rdy_o),
    .grant_o    (grant_o),
    .grant_vld_o(grant_vld_o),
    .skid_sel_o (skid_sel_o),
`ifdef MEMSHARE_SCHED_STAT_EN
    .conflict_cnt_o(conflict_cnt_o),
`endif
    .busy_o     (busy_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Observed vector layout: {rdy, grant[4:0], grant_vld, skid_sel, busy}
  function automatic logic [8:0] obs();
    return {rqst_rdy_o, grant_o, grant_vld_o, skid_sel_o, busy_o};
  endfunction

  // Table entries are {rdy, grant[4:0], sel, busy}; grant_vld is derived.
  function automatic logic [8:0] widen(input logic [7:0] e);
    return {e[7], e[6:2], |e[6:2], e[1], e[0]};
  endfunction

  task automatic apply_reset();
    @(negedge sys_clk);
    rqst_vld_i  = 1'b0;
    rqst_flag_i = '0;
    rstn        = 1'b0;
    @(negedge sys_clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn        = 1'b0;
    rqst_vld_i  = 1'b1;
    rqst_flag_i = 5'b11111;
    #1;
    tests++;
    if (obs() !== 9'b0) begin
      fails++;
      $display("FAIL reset_initial: got %b want %b", obs(), 9'b0);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    tests++;
    if (obs() !== 9'b0) begin
      fails++;
      $display("FAIL reset_clocked: got %b want %b", obs(), 9'b0);
    end
    @(negedge sys_clk);
    rqst_vld_i = 1'b0;
    rstn       = 1'b1;
  endtask

  task automatic test_single();
    logic       v [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0] f [3] = '{5'b00100, 5'b00000, 5'b11111};
    logic [7:0] e [3] = '{8'b1_00100_0_0, 8'b1_00000_0_0, 8'b1_01000_0_0};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      rqst_vld_i = v[c]; rqst_flag_i = f[c];
      #1;
      tests++;
      if (obs() !== widen(e[c])) begin
        fails++;
        $display("FAIL single cyc %0d: got %b want %b", c, obs(), widen(e[c]));
      end
    end
  endtask

  task automatic test_multi();
    logic       v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] f [4] = '{5'b10011, 5'b00000, 5'b00000, 5'b00000};
    logic [7:0] e [4] = '{8'b1_00001_0_0, 8'b0_00010_1_1, 8'b1_10000_1_1, 8'b1_00000_0_0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      rqst_vld_i = v[c]; rqst_flag_i = f[c];
      #1;
      tests++;
      if (obs() !== widen(e[c])) begin
        fails++;
        $display("FAIL multi cyc %0d: got %b want %b", c, obs(), widen(e[c]));
      end
    end
  endtask

  task automatic test_ptr_wrap();
    logic       v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] f [5] = '{5'b01000, 5'b10001, 5'b00000, 5'b00011, 5'b00000};
    logic [7:0] e [5] = '{8'b1_01000_0_0, 8'b1_10000_0_0, 8'b1_00001_1_1,
                          8'b1_00010_0_0, 8'b1_00001_1_1};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      rqst_vld_i = v[c]; rqst_flag_i = f[c];
      #1;
      tests++;
      if (obs() !== widen(e[c])) begin
        fails++;
        $display("FAIL ptr_wrap cyc %0d: got %b want %b", c, obs(), widen(e[c]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       v [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] f [6] = '{5'b10011, 5'b00000, 5'b01100, 5'b00000, 5'b00000, 5'b00000};
    logic [7:0] e [6] = '{8'b1_00001_0_0, 8'b0_00010_1_1, 8'b1_10000_1_1,
                          8'b0_00100_1_1, 8'b1_01000_1_1, 8'b1_00000_0_0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge sys_clk);
      rqst_vld_i = v[c]; rqst_flag_i = f[c];
      #1;
      tests++;
      if (obs() !== widen(e[c])) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", c, obs(), widen(e[c]));
      end
    end
  endtask

  task automatic test_zero_vec();
    logic       v [3] = '{1'b1, 1'b0, 1'b1};
    logic [4:0] f [3] = '{5'b00000, 5'b00000, 5'b11111};
    logic [7:0] e [3] = '{8'b1_00000_0_0, 8'b1_00000_0_0, 8'b1_00001_0_0};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      rqst_vld_i = v[c]; rqst_flag_i = f[c];
      #1;
      tests++;
      if (obs() !== widen(e[c])) begin
        fails++;
        $display("FAIL zero_vec cyc %0d: got %b want %b", c, obs(), widen(e[c]));
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge sys_clk);
    rqst_vld_i = 1'b1; rqst_flag_i = 5'b10011;
    @(negedge sys_clk);
    rqst_vld_i = 1'b1; rqst_flag_i = 5'b11111;
    #1;
    tests++;
    if (obs() !== 9'b0_00010_1_1_1) begin
      fails++;
      $display("FAIL async_pre: got %b want %b", obs(), 9'b0_00010_1_1_1);
    end
    #1 rstn = 1'b0;
    #1;
    tests++;
    if (obs() !== 9'b0) begin
      fails++;
      $display("FAIL async_assert: got %b want %b", obs(), 9'b0);
    end
    @(posedge sys_clk);
    #1;
    tests++;
    if (obs() !== 9'b0) begin
      fails++;
      $display("FAIL async_hold: got %b want %b", obs(), 9'b0);
    end
    @(negedge sys_clk);
    rstn = 1'b1; rqst_vld_i = 1'b0;
    #1;
    tests++;
    if (obs() !== 9'b1_00000_0_0_0) begin
      fails++;
      $display("FAIL async_release: got %b want %b", obs(), 9'b1_00000_0_0_0);
    end
    @(negedge sys_clk);
    rqst_vld_i = 1'b1; rqst_flag_i = 5'b11111;
    #1;
    tests++;
    if (obs() !== 9'b1_00001_1_0_0) begin
      fails++;
      $display("FAIL async_ptr0: got %b want %b", obs(), 9'b1_00001_1_0_0);
    end
  endtask

  // Reference: pend is the set of requesters still owed a grant, ptr the
  // round-robin start. Each cycle serves the first owed requester from ptr.
  task automatic test_random();
    logic [N-1:0] pend, src, eg;
    int           rr, gi, k;
    logic         er, acc, eb;
    logic [8:0]   ex;
    apply_reset();
    pend = '0;
    rr   = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      rqst_vld_i  = ($urandom_range(0, 3) != 0);
      rqst_flag_i = N'($urandom);
      #1;
      eb  = (pend != '0);
      er  = !eb || ($countones(pend) == 1);
      acc = rqst_vld_i && er;
      src = eb ? pend : (acc ? rqst_flag_i : '0);
      eg  = '0;
      gi  = -1;
      for (int i = 0; i < N; i++) begin
        k = (rr + i) % N;
        if (gi < 0 && src[k]) gi = k;
      end
      if (gi >= 0) begin
        eg[gi] = 1'b1;
        rr     = (gi + 1) % N;
      end
      ex = {er, eg, |eg, eb, eb};
      tests++;
      if (obs() !== ex) begin
        fails++;
        $display("FAIL random cyc %0d: got %b want %b", c, obs(), ex);
      end
      if (acc) pend = eb ? rqst_flag_i : (rqst_flag_i & ~eg);
      else     pend = pend & ~eg;
    end
    @(negedge sys_clk);
    rqst_vld_i = 1'b0;
  endtask

`ifdef MEMSHARE_SCHED_STAT_EN
  task automatic test_stat();
    logic [4:0] vecs [3] = '{5'b00001, 5'b00011, 5'b11111};
    int         waited;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      waited = 0;
      while (!rqst_rdy_o && waited < 20) begin
        @(negedge sys_clk);
        waited++;
      end
      rqst_vld_i = 1'b1; rqst_flag_i = vecs[i];
      @(negedge sys_clk);
      rqst_vld_i = 1'b0;
    end
    waited = 0;
    while (busy_o && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    tests++;
    if (conflict_cnt_o !== 16'd2) begin
      fails++;
      $display("FAIL stat_count: got %0d want %0d", conflict_cnt_o, 2);
    end
  endtask
`endif

  initial begin
    rqst_vld_i  = 1'b0;
    rqst_flag_i = '0;
    rstn        = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_ptr_wrap();
    test_back_to_back();
    test_zero_vec();
    test_async_reset();
    test_random();
`ifdef MEMSHARE_SCHED_STAT_EN
    test_stat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
